// File: rtl/aud_recorder.sv
// aud_recorder
//   Captures the left channel of an I2S codec ADC stream (16-bit, MSB first)
//   and emits one SRAM write per sample at consecutive word addresses,
//   stopping once the word at ADDR_MAX has been written.
// Ports
//   i_clk      codec bit clock (BCLK), rising-edge logic
//   i_rst_n    synchronous active-low reset
//   i_lrc      ADCLRC, low = left channel
//   i_data     ADCDAT serial data
//   i_start    pulse: start recording / resume from pause
//   i_pause    pulse: pause after the current sample completes
//   i_stop     pulse: abort, return to idle
//   o_address  SRAM word address of the current/next write
//   o_data     captured left-channel sample
//   o_wr       one-cycle write strobe
//   o_full     set once the word at ADDR_MAX has been written
module aud_recorder #(
    parameter logic [19:0] ADDR_MAX = 20'hFFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lrc,
    input  logic        i_data,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    output logic [19:0] o_address,
    output logic [15:0] o_data,
    output logic        o_wr,
    output logic        o_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_STORE,
        S_PAUSE,
        S_FULL
    } state_t;

    state_t      state_q, state_d;
    logic        lrc_q;            // i_lrc delayed by one cycle
    logic [15:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        full_q, full_d;
    logic        lrc_fall;

    assign lrc_fall = lrc_q & ~i_lrc;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        full_d  = full_q;

        case (state_q)
            S_IDLE, S_FULL: begin
                // stop and pause outrank start even where they have no effect
                if (!i_stop && !i_pause && i_start) begin
                    addr_d  = '0;
                    full_d  = 1'b0;
                    pend_d  = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pend_q || i_pause) begin
                    pend_d  = 1'b0;
                    state_d = S_PAUSE;
                end else if (lrc_fall) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[14:0], i_data};
                cnt_d   = cnt_q + 4'd1;
                if (i_pause) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == 4'd15) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                data_d  = shift_q;
                wr_d    = 1'b1;
                state_d = S_WAIT;
                if (i_pause) begin
                    pend_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (!i_stop && !i_pause && i_start) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address advance happens the cycle after the strobe; reaching
        // ADDR_MAX overrides whatever the S_WAIT branch chose.
        if (wr_q) begin
            if (addr_q == ADDR_MAX) begin
                full_d  = 1'b1;
                pend_d  = 1'b0;
                state_d = S_FULL;
            end else begin
                addr_d = addr_q + 20'd1;
            end
        end

        // A write already strobed still advances the address; only the
        // in-flight sample is discarded.
        if (i_stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            wr_d    = 1'b0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            lrc_q   <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lrc_q   <= i_lrc;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            full_q  <= full_d;
        end
    end

    assign o_address = addr_q;
    assign o_data    = data_q;
    assign o_wr      = wr_q;
    assign o_full    = full_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder. A default-depth instance carries most of
// the sequence; a second instance with ADDR_MAX=3 exercises the full limit.
// Expected writes are queued as frames are driven and popped by monitors.
module tb_aud_recorder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, lrc, dat, start, pause, stop, start_s;
    logic [19:0] addr_m, addr_s;
    logic [15:0] data_m, data_s;
    logic        wr_m, wr_s, full_m, full_s;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned fall_cyc = 0;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         sb_m[$];
    wr_t         sb_s[$];
    wr_t         em, es;
    logic [19:0] nxt_m, nxt_s;
    logic        pend_m = 1'b0;
    logic        pend_s = 1'b0;
    logic        full_exp_s;

    always @(posedge clk) cyc++;

    aud_recorder u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_lrc    (lrc),
        .i_data   (dat),
        .i_start  (start),
        .i_pause  (pause),
        .i_stop   (stop),
        .o_address(addr_m),
        .o_data   (data_m),
        .o_wr     (wr_m),
        .o_full   (full_m)
    );

    aud_recorder #(.ADDR_MAX(20'd3)) u_dut_s (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_lrc    (lrc),
        .i_data   (dat),
        .i_start  (start_s),
        .i_pause  (pause),
        .i_stop   (stop),
        .o_address(addr_s),
        .o_data   (data_s),
        .o_wr     (wr_s),
        .o_full   (full_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One I2S frame: lrc falls, left word MSB follows one clock later,
    // lrc rises alongside the left LSB, then the right word.
    task automatic frame(input logic [15:0] l, input logic [15:0] r,
                         input int pause_at, input int stop_at, input int rst_at);
        lrc      = 1'b0;
        fall_cyc = cyc;
        tick();
        for (int k = 0; k < 16; k++) begin
            dat   = l[15-k];
            if (k == 15) lrc = 1'b1;
            pause = (k == pause_at);
            stop  = (k == stop_at);
            rst_n = (k != rst_at);
            tick();
            pause = 1'b0;
            stop  = 1'b0;
            if (k == rst_at) begin
                rst_n = 1'b1;
                check("rst_mid_addr", addr_m, 20'd0);
                check("rst_mid_data", data_m, 16'd0);
                check("rst_mid_wr",   wr_m,   1'b0);
                check("rst_mid_full", full_m, 1'b0);
            end
        end
        for (int k = 0; k < 16; k++) begin
            dat = r[15-k];
            tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic expect_m(input logic [19:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_m.push_back(e);
    endtask

    task automatic expect_s(input logic [19:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb_s.push_back(e);
    endtask

    always @(negedge clk) begin
        if (wr_m) begin
            check("m_wr_expected", sb_m.size() > 0, 1'b1);
            if (sb_m.size() > 0) begin
                em = sb_m.pop_front();
                check("m_wr_addr", addr_m, em.addr);
                check("m_wr_data", data_m, em.data);
                check("m_wr_latency", cyc - fall_cyc, 18);
                nxt_m  = (em.addr == 20'hFFFFF) ? em.addr : em.addr + 20'd1;
                pend_m = 1'b1;
            end
        end else if (pend_m) begin
            pend_m = 1'b0;
            check("m_addr_next", addr_m, nxt_m);
        end
    end

    always @(negedge clk) begin
        if (wr_s) begin
            check("s_wr_expected", sb_s.size() > 0, 1'b1);
            if (sb_s.size() > 0) begin
                es = sb_s.pop_front();
                check("s_wr_addr", addr_s, es.addr);
                check("s_wr_data", data_s, es.data);
                check("s_wr_latency", cyc - fall_cyc, 18);
                full_exp_s = (es.addr == 20'd3);
                nxt_s  = full_exp_s ? es.addr : es.addr + 20'd1;
                pend_s = 1'b1;
            end
        end else if (pend_s) begin
            pend_s = 1'b0;
            check("s_addr_next", addr_s, nxt_s);
            check("s_full_next", full_s, full_exp_s);
        end
    end

    initial begin
        rst_n   = 1'b0;
        lrc     = 1'b1;
        dat     = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        stop    = 1'b0;
        start_s = 1'b0;
        repeat (3) tick();
        check("reset_addr", addr_m, 20'd0);
        check("reset_data", data_m, 16'd0);
        check("reset_wr",   wr_m,   1'b0);
        check("reset_full", full_m, 1'b0);
        rst_n = 1'b1;
        tick();

        // single sample, first address
        pulse_start();
        check("start_addr", addr_m, 20'd0);
        expect_m(20'd0, 16'hA5C3);
        frame(16'hA5C3, 16'h1234, -1, -1, -1);
        check("after_first_addr", addr_m, 20'd1);

        // restart and three consecutive frames; right words differ
        pulse_stop();
        pulse_start();
        check("restart_addr", addr_m, 20'd0);
        expect_m(20'd0, 16'h0001);
        frame(16'h0001, 16'hBEEF, -1, -1, -1);
        expect_m(20'd1, 16'h8000);
        frame(16'h8000, 16'h7FFF, -1, -1, -1);
        expect_m(20'd2, 16'hFFFF);
        frame(16'hFFFF, 16'h0000, -1, -1, -1);
        check("three_frames_addr", addr_m, 20'd3);

        // pause during shift: sample completes, then nothing until resume
        expect_m(20'd3, 16'h1357);
        frame(16'h1357, 16'hAAAA, 4, -1, -1);
        frame(16'h2468, 16'h5555, -1, -1, -1);
        check("paused_addr", addr_m, 20'd4);
        pulse_start();
        expect_m(20'd4, 16'h9ABC);
        frame(16'h9ABC, 16'h0F0F, -1, -1, -1);
        check("resumed_addr", addr_m, 20'd5);

        // stop at bit 8: no write, idle ignores frames, start clears address
        frame(16'h7777, 16'h3333, -1, 8, -1);
        check("stop_addr_hold", addr_m, 20'd5);
        frame(16'h1111, 16'h2222, -1, -1, -1);
        pulse_start();
        check("stop_restart_addr", addr_m, 20'd0);
        check("stop_restart_full", full_m, 1'b0);
        expect_m(20'd0, 16'h4242);
        frame(16'h4242, 16'h6666, -1, -1, -1);

        // stop and pause together go idle (start clears, not resumes)
        frame(16'h5A5A, 16'hA5A5, 5, 5, -1);
        check("stop_pause_addr", addr_m, 20'd1);
        pulse_start();
        check("stop_pause_restart", addr_m, 20'd0);
        expect_m(20'd0, 16'hC0DE);
        frame(16'hC0DE, 16'h1111, -1, -1, -1);
        check("pre_reset_data", data_m, 16'hC0DE);

        // reset mid-sample: outputs cleared, partial sample dropped
        frame(16'hDEAD, 16'hBEEF, -1, -1, 8);
        check("post_reset_addr", addr_m, 20'd0);

        // ADDR_MAX=3 instance fills up
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_s(20'(i), 16'h1000 + 16'(i));
            frame(16'h1000 + 16'(i), 16'hFACE, -1, -1, -1);
        end
        check("full_flag", full_s, 1'b1);
        check("full_addr", addr_s, 20'd3);
        frame(16'h1004, 16'hFACE, -1, -1, -1);
        check("full_hold_flag", full_s, 1'b1);
        check("full_hold_addr", addr_s, 20'd3);
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        check("full_restart_addr", addr_s, 20'd0);
        check("full_restart_flag", full_s, 1'b0);

        repeat (3) tick();
        check("m_scoreboard_empty", sb_m.size(), 0);
        check("s_scoreboard_empty", sb_s.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aud_recorder.md
AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 The block SHALL have parameter ADDR_MAX, default 20'hFFFFF, the last SRAM word address that may be written.
REQ-002 The block SHALL have port i_clk  input  1  codec bit clock (BCLK); all logic is on the rising edge.
REQ-003 The block SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port i_lrc  input  1  codec ADC LR clock (ADCLRC); low = left channel.
REQ-005 The block SHALL have port i_data  input  1  codec ADC serial data (ADCDAT), I2S format, MSB first, 16-bit.
REQ-006 The block SHALL have port i_start  input  1  single-cycle pulse: begin recording, or resume from pause.
REQ-007 The block SHALL have port i_pause  input  1  single-cycle pulse: request pause.
REQ-008 The block SHALL have port i_stop  input  1  single-cycle pulse: abort and return to idle.
REQ-009 The block SHALL have port o_address  output  20  SRAM word address of the current/next write.
REQ-010 The block SHALL have port o_data  output  16  captured left-channel sample.
REQ-011 The block SHALL have port o_wr  output  1  one-cycle write strobe; o_address and o_data are valid while high.
REQ-012 The block SHALL have port o_full  output  1  high once the word at ADDR_MAX has been written.

Function
REQ-013 States SHALL be S_IDLE, S_WAIT, S_SHIFT, S_STORE, S_PAUSE, S_FULL.
REQ-014 A register lrc_d SHALL hold i_lrc delayed by one cycle; a falling edge is lrc_d==1 && i_lrc==0.
REQ-015 S_IDLE: on i_start, o_address <= 0, o_full <= 0, pause_pend <= 0, go to S_WAIT; otherwise hold.
REQ-016 S_WAIT: if pause_pend, clear it and go to S_PAUSE; else on an lrc falling edge, bit counter <= 0 and go to S_SHIFT.
REQ-017 S_SHIFT: each cycle, shift_reg <= {shift_reg[14:0], i_data}; the first sample is taken on the cycle after the falling edge (I2S one-bit delay); after the 16th bit (counter==15), go to S_STORE.
REQ-018 S_STORE (one cycle): o_data <= shift_reg, o_wr <= 1; then go to S_WAIT.
REQ-019 o_wr SHALL be high for exactly one cycle per sample, with o_address unchanged during that cycle.
REQ-020 On the cycle after o_wr, o_address SHALL increment by 1. If the written address equals ADDR_MAX, o_address SHALL hold instead, o_full <= 1, and the state SHALL go to S_FULL.
REQ-021 S_FULL: hold all outputs with o_wr=0; i_start SHALL behave as in S_IDLE (restart from address 0).
REQ-022 i_pause received in S_WAIT SHALL go to S_PAUSE next cycle; in S_SHIFT/S_STORE it SHALL set pause_pend so that the current sample completes first.
REQ-023 S_PAUSE: o_address is retained; i_start goes to S_WAIT; no writes occur while paused.
REQ-024 i_stop in any state other than S_IDLE SHALL go to S_IDLE next cycle, with o_wr=0, pause_pend cleared, and any partial sample discarded; o_address holds its value.
REQ-025 Simultaneous pulses SHALL be resolved with priority i_stop > i_pause > i_start.
REQ-026 i_lrc rising edges (right channel) SHALL be ignored.
REQ-027 o_address arithmetic SHALL be 20-bit unsigned and SHALL never wrap past ADDR_MAX.

Reset
REQ-028 While i_rst_n==0 at a rising i_clk edge: state=S_IDLE, o_address=0, o_data=0, o_wr=0, o_full=0, lrc_d=1, shift_reg=0, bit counter=0, pause_pend=0.
REQ-029 Reset asserted mid-sample SHALL discard the partial sample with no o_wr pulse.

Verification
REQ-030 Reset, i_start, then an I2S left word 16'hA5C3 after an lrc falling edge -> o_wr pulses once, 18 cycles after the edge, with o_data=16'hA5C3 and o_address=0; o_address=1 on the next cycle.
REQ-031 Three consecutive frames 16'h0001, 16'h8000, 16'hFFFF -> writes at addresses 0,1,2 with matching data; right-channel data is never written.
REQ-032 i_pause mid-S_SHIFT -> that sample is still written, no further writes while paused; i_start -> the next sample is written at the following address.
REQ-033 ADDR_MAX=3, four frames -> writes at 0..3, o_full=1, o_address=3; a fifth frame produces no o_wr.
REQ-034 i_stop asserted at bit 8 of a sample -> no o_wr, state S_IDLE; i_start then resets o_address to 0.
REQ-035 i_stop and i_pause asserted in the same cycle -> S_IDLE; i_rst_n=0 mid-sample -> all outputs 0 on the next edge.
